// File: rtl/fifo_stream_pkg.sv
// Shared types and defaults for the FIFO read-side streaming stage.
package fifo_stream_pkg;
  localparam int DATA_W_DEF  = 16;
  localparam int PKT_LEN_DEF = 4;
  localparam int CNT_W_DEF   = 16;

  typedef logic [1:0] occ_t;
  typedef logic [$clog2(PKT_LEN_DEF)-1:0] beat_t;
endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry output buffer: head drives the stream, tail catches a landing word.
module stream_skid_buf2
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output occ_t              occ
);

  logic [DATA_W-1:0] tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= din;
          else             tail <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: landing word goes behind whatever remains.
          if (occ == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains a synchronous FIFO into a framed valid/ready stream at one word per cycle.
module fifo_rd_streamer
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PKT_LEN = PKT_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic              fifo_underflow,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              flush,
  output logic              underflow_err,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  occ_t              occ;
  logic              inflight;
  logic              pop;
  logic              push;
  logic [2:0]        demand;
  logic [BEAT_W-1:0] beat;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_last  = m_valid & (beat == LAST_BEAT);

  // Slots committed after this edge; a read is only issued if it will have room.
  assign demand     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = !rst && !flush && !fifo_empty && (demand < 3'd2);
  assign push       = inflight & !fifo_underflow & !flush;

  stream_skid_buf2 #(.DATA_W(DATA_W)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (fifo_dout),
    .head  (m_data),
    .occ   (occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight      <= 1'b0;
      underflow_err <= 1'b0;
      beat          <= '0;
      word_cnt      <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight && fifo_underflow) underflow_err <= 1'b1;
      if (flush)    beat <= '0;
      else if (pop) beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      if (pop && (word_cnt != '1)) word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: behavioural FIFO feeding the DUT, scoreboard on the stream.
module tb_fifo_rd_streamer;
  localparam int DW = 16;
  localparam int PL = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_underflow = 1'b0;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          flush;
  logic          underflow_err;
  logic [CW-1:0] word_cnt;

  logic [DW-1:0] mem [64];
  logic [5:0]    rd_ptr = '0;
  logic [5:0]    wr_ptr;
  logic          force_uf;

  logic [DW-1:0] exp_d [$];
  logic          exp_l [$];
  logic [DW-1:0] obs_d [$];
  logic          obs_l [$];
  logic          rd_h [$];
  logic          v_h [$];
  logic          r_h [$];
  logic          l_h [$];
  logic [DW-1:0] d_h [$];

  int vectors = 0;
  int errors  = 0;
  int exp_beat = 0;
  int exp_cnt  = 0;

  fifo_rd_streamer #(.DATA_W(DW), .PKT_LEN(PL), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_dout      (fifo_dout),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .flush          (flush),
    .underflow_err  (underflow_err),
    .word_cnt       (word_cnt)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  // One-cycle-latency FIFO; force_uf turns the next read into an underflow that still consumes a word.
  always @(posedge clk) begin
    fifo_underflow <= 1'b0;
    if (fifo_rd_en) begin
      if (rd_ptr == wr_ptr || force_uf) begin
        fifo_underflow <= 1'b1;
        fifo_dout      <= 16'hDEAD;
      end else begin
        fifo_dout <= mem[rd_ptr];
      end
      if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 6'd1;
    end
  end

  task automatic push_exp(input logic [DW-1:0] d);
    exp_d.push_back(d);
    exp_l.push_back(exp_beat == PL - 1);
    exp_beat = (exp_beat + 1) % PL;
    exp_cnt++;
  endtask

  task automatic load(input int n, input int base, input bit expect_all);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = DW'(base + i);
      wr_ptr = wr_ptr + 6'd1;
      if (expect_all) push_exp(DW'(base + i));
    end
  endtask

  task automatic clear_hist();
    rd_h.delete(); v_h.delete(); r_h.delete(); l_h.delete(); d_h.delete();
  endtask

  // Advance one cycle: sample at negedge, return at posedge+1 for driving.
  task automatic tick();
    @(negedge clk);
    rd_h.push_back(fifo_rd_en);
    v_h.push_back(m_valid);
    r_h.push_back(m_ready);
    d_h.push_back(m_data);
    l_h.push_back(m_last);
    if (m_valid && m_ready) begin
      obs_d.push_back(m_data);
      obs_l.push_back(m_last);
    end
    assert (int'(dut.occ) + int'(dut.inflight) <= 2)
      else $error("FAIL occ_invariant: occ %0d inflight %0d", dut.occ, dut.inflight);
    @(posedge clk); #1;
  endtask

  function automatic int first_one(input logic q[$]);
    foreach (q[i]) if (q[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int run_len(input logic q[$], input int start);
    int n = 0;
    if (start < 0) return 0;
    for (int i = start; i < q.size() && q[i] === 1'b1; i++) n++;
    return n;
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    vectors++; if (m_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", m_data); end
    vectors++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", m_last); end
    vectors++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", underflow_err); end
    vectors++; if (word_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", word_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    int i0;
    logic [DW-1:0] od, ed;
    logic ol, el;
    clear_hist();
    m_ready = 1'b1;
    load(8, 'h0001, 1'b1);
    repeat (14) tick();
    i0 = first_one(rd_h);
    vectors++; if (run_len(rd_h, i0) != 8) begin errors++; $display("FAIL stream_rd_run: got %0d want 8", run_len(rd_h, i0)); end
    vectors++; if (first_one(v_h) != i0 + 2) begin errors++; $display("FAIL stream_latency: got %0d want %0d", first_one(v_h), i0 + 2); end
    vectors++; if (run_len(v_h, first_one(v_h)) != 8) begin errors++; $display("FAIL stream_valid_run: got %0d want 8", run_len(v_h, first_one(v_h))); end
    while (obs_d.size() != 0 && exp_d.size() != 0) begin
      od = obs_d.pop_front(); ol = obs_l.pop_front(); ed = exp_d.pop_front(); el = exp_l.pop_front();
      vectors++; if ({od, ol} !== {ed, el}) begin errors++; $display("FAIL stream_beat: got %h/%b want %h/%b", od, ol, ed, el); end
    end
    vectors++; if (obs_d.size() + exp_d.size() != 0) begin errors++; $display("FAIL stream_count: leftover obs %0d exp %0d", obs_d.size(), exp_d.size()); end
    vectors++; if (word_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL stream_cnt: got %0d want %0d", word_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    logic [DW-1:0] od, ed;
    logic ol, el;
    clear_hist();
    m_ready = 1'b0;
    load(8, 'h0001, 1'b1);
    repeat (10) tick();
    foreach (rd_h[i]) if (rd_h[i] === 1'b1) pulses++;
    vectors++; if (pulses != 2) begin errors++; $display("FAIL bp_rd_pulses: got %0d want 2", pulses); end
    vectors++; if (dut.occ !== 2'd2) begin errors++; $display("FAIL bp_occ: got %0d want 2", dut.occ); end
    vectors++; if (m_data !== 16'h0001) begin errors++; $display("FAIL bp_hold: got %h want 0001", m_data); end
    m_ready = 1'b1;
    repeat (14) tick();
    while (obs_d.size() != 0 && exp_d.size() != 0) begin
      od = obs_d.pop_front(); ol = obs_l.pop_front(); ed = exp_d.pop_front(); el = exp_l.pop_front();
      vectors++; if ({od, ol} !== {ed, el}) begin errors++; $display("FAIL bp_beat: got %h/%b want %h/%b", od, ol, ed, el); end
    end
    vectors++; if (obs_d.size() + exp_d.size() != 0) begin errors++; $display("FAIL bp_count: leftover obs %0d exp %0d", obs_d.size(), exp_d.size()); end
  endtask

  task automatic test_toggle();
    int bad = 0;
    logic [DW-1:0] od, ed;
    logic ol, el;
    clear_hist();
    load(6, 'h0101, 1'b1);
    for (int i = 0; i < 20; i++) begin
      m_ready = (i % 2 == 0);
      tick();
    end
    m_ready = 1'b1;
    repeat (6) tick();
    for (int k = 1; k < v_h.size(); k++)
      if (v_h[k-1] && !r_h[k-1] && (!v_h[k] || d_h[k] !== d_h[k-1] || l_h[k] !== l_h[k-1])) bad++;
    vectors++; if (bad != 0) begin errors++; $display("FAIL toggle_stall_hold: got %0d violations want 0", bad); end
    while (obs_d.size() != 0 && exp_d.size() != 0) begin
      od = obs_d.pop_front(); ol = obs_l.pop_front(); ed = exp_d.pop_front(); el = exp_l.pop_front();
      vectors++; if ({od, ol} !== {ed, el}) begin errors++; $display("FAIL toggle_beat: got %h/%b want %h/%b", od, ol, ed, el); end
    end
    vectors++; if (obs_d.size() + exp_d.size() != 0) begin errors++; $display("FAIL toggle_count: leftover obs %0d exp %0d", obs_d.size(), exp_d.size()); end
    vectors++; if (word_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL toggle_cnt: got %0d want %0d", word_cnt, exp_cnt); end
  endtask

  task automatic test_underflow();
    logic [DW-1:0] od, ed;
    logic ol, el;
    m_ready = 1'b1;
    load(4, 'h0201, 1'b0);
    push_exp(16'h0202); push_exp(16'h0203); push_exp(16'h0204);
    force_uf = 1'b1;
    tick();
    force_uf = 1'b0;
    repeat (8) tick();
    while (obs_d.size() != 0 && exp_d.size() != 0) begin
      od = obs_d.pop_front(); ol = obs_l.pop_front(); ed = exp_d.pop_front(); el = exp_l.pop_front();
      vectors++; if ({od, ol} !== {ed, el}) begin errors++; $display("FAIL uf_beat: got %h/%b want %h/%b", od, ol, ed, el); end
    end
    vectors++; if (obs_d.size() + exp_d.size() != 0) begin errors++; $display("FAIL uf_count: leftover obs %0d exp %0d", obs_d.size(), exp_d.size()); end
    vectors++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_err: got %b want 1", underflow_err); end
    repeat (5) tick();
    vectors++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", underflow_err); end
    vectors++; if (word_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL uf_cnt: got %0d want %0d", word_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    logic [DW-1:0] od, ed;
    logic ol, el;
    m_ready = 1'b0;
    load(4, 'h0301, 1'b0);
    push_exp(16'h0301);
    repeat (4) tick();
    vectors++; if (dut.occ !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d want 2", dut.occ); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    flush = 1'b1;
    #0;
    vectors++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL flush_rd_en: got %b want 0", fifo_rd_en); end
    wr_ptr = rd_ptr;
    tick();
    flush = 1'b0;
    vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", m_valid); end
    vectors++; if (dut.beat !== '0) begin errors++; $display("FAIL flush_beat: got %0d want 0", dut.beat); end
    repeat (2) tick();
    vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_inflight_drop: got %b want 0", m_valid); end
    exp_beat = 0;
    m_ready = 1'b1;
    load(8, 'h00A0, 1'b1);
    repeat (14) tick();
    while (obs_d.size() != 0 && exp_d.size() != 0) begin
      od = obs_d.pop_front(); ol = obs_l.pop_front(); ed = exp_d.pop_front(); el = exp_l.pop_front();
      vectors++; if ({od, ol} !== {ed, el}) begin errors++; $display("FAIL flush_beat_seq: got %h/%b want %h/%b", od, ol, ed, el); end
    end
    vectors++; if (obs_d.size() + exp_d.size() != 0) begin errors++; $display("FAIL flush_count: leftover obs %0d exp %0d", obs_d.size(), exp_d.size()); end
    vectors++; if (word_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL flush_cnt: got %0d want %0d", word_cnt, exp_cnt); end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] od, ed;
    logic ol, el;
    m_ready = 1'b1;
    load(8, 'h0401, 1'b0);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL arst_rd_en: got %b want 0", fifo_rd_en); end
    vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", m_valid); end
    vectors++; if (m_data !== '0) begin errors++; $display("FAIL arst_data: got %h want 0", m_data); end
    vectors++; if (m_last !== 1'b0) begin errors++; $display("FAIL arst_last: got %b want 0", m_last); end
    vectors++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL arst_err: got %b want 0", underflow_err); end
    vectors++; if (word_cnt !== '0) begin errors++; $display("FAIL arst_cnt: got %0d want 0", word_cnt); end
    wr_ptr = rd_ptr;
    tick();
    rst = 1'b0;
    obs_d.delete(); obs_l.delete(); exp_d.delete(); exp_l.delete();
    exp_beat = 0;
    exp_cnt  = 0;
    load(4, 'h0501, 1'b1);
    repeat (10) tick();
    while (obs_d.size() != 0 && exp_d.size() != 0) begin
      od = obs_d.pop_front(); ol = obs_l.pop_front(); ed = exp_d.pop_front(); el = exp_l.pop_front();
      vectors++; if ({od, ol} !== {ed, el}) begin errors++; $display("FAIL arst_beat: got %h/%b want %h/%b", od, ol, ed, el); end
    end
    vectors++; if (obs_d.size() + exp_d.size() != 0) begin errors++; $display("FAIL arst_count: leftover obs %0d exp %0d", obs_d.size(), exp_d.size()); end
    vectors++; if (word_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL arst_cnt_restart: got %0d want %0d", word_cnt, exp_cnt); end
  endtask

  initial begin
    rst      = 1'b1;
    m_ready  = 1'b0;
    flush    = 1'b0;
    force_uf = 1'b0;
    wr_ptr   = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_underflow();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
